// File: rtl/um6845r_crtc.sv
// UM6845R / HD6845S-compatible CRT controller: register file, CPU read map and
// character/raster/row timing with registered video outputs.
module um6845r_crtc (
  input  logic        clock,
  input  logic        reset,
  input  logic        crtc_type,
  input  logic        clken,
  input  logic        enable,
  input  logic        n_cs,
  input  logic        r_nw,
  input  logic        rs,
  input  logic [7:0]  di,
  output logic [7:0]  dout,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        hblank,
  output logic        vblank,
  output logic        field,
  output logic        cursor,
  output logic [13:0] ma,
  output logic [4:0]  ra
);
  logic [7:0]  r0, r1, r2, r3, r13, r15;
  logic [6:0]  r4, r6, r7, r10;
  logic [4:0]  r5, r9, r11, addr;
  logic [5:0]  r12, r14;
  logic [1:0]  r8;

  logic [7:0]  hcc;
  logic [6:0]  vcc;
  logic [4:0]  rac;
  logic        in_adj, field_q;
  logic [13:0] ma_row;
  logic [3:0]  hs_cnt, vs_cnt;
  logic [5:0]  blink_cnt;

  logic        line_end, last_row, frame_end, enter_adj;
  logic        hs_start, hs_now, vs_start, vs_now, hb, vb, blink_on, cur_now;
  logic [13:0] base, ma_now;

  // The first scanline of a frame always fetches from the start address.
  assign base      = (vcc == 7'd0 && rac == 5'd0 && !in_adj) ? {r12, r13} : ma_row;
  assign ma_now    = base + {6'd0, hcc};
  assign line_end  = (hcc == r0);
  assign last_row  = (rac == r9);
  assign enter_adj = !in_adj && last_row && vcc == r4 && r5 != 5'd0;
  assign frame_end = in_adj ? (rac + 5'd1 == r5) : (last_row && vcc == r4 && r5 == 5'd0);
  assign hs_start  = (hcc == r2) && (r3[3:0] != 4'd0);
  assign hs_now    = hs_start || (hs_cnt != 4'd0);
  assign vs_start  = (vcc == r7) && (rac == 5'd0) && !in_adj;
  assign vs_now    = vs_start || (vs_cnt != 4'd0);
  assign hb        = (hcc >= r1);
  assign vb        = (vcc >= r6) || in_adj;

  always_comb begin
    case (r10[6:5])
      2'b00:   blink_on = 1'b1;
      2'b01:   blink_on = 1'b0;
      2'b10:   blink_on = ~blink_cnt[4];
      default: blink_on = ~blink_cnt[5];
    endcase
  end

  assign cur_now = !hb && !vb && (ma_now == {r14, r15}) &&
                   (rac >= r10[4:0]) && (rac <= r11) && blink_on;

  // Read map: cursor address always visible, start address only on UM6845R.
  always_comb begin
    dout = 8'hFF;
    if (!n_cs && r_nw) begin
      if (!rs) dout = crtc_type ? {2'b00, vblank, 5'b0} : 8'h00;
      else begin
        case (addr)
          5'd8:    dout = {6'd0, r8} & 8'h00;
          5'd12:   dout = crtc_type ? {2'b00, r12} : 8'h00;
          5'd13:   dout = crtc_type ? r13 : 8'h00;
          5'd14:   dout = {2'b00, r14};
          5'd15:   dout = r15;
          default: dout = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      {r0, r1, r2, r3, r13, r15} <= '0;
      {r4, r6, r7, r10}          <= '0;
      {r5, r9, r11, addr}        <= '0;
      {r12, r14}                 <= '0;
      r8                         <= '0;
    end else if (clken && !n_cs && !r_nw) begin
      if (!rs) addr <= di[4:0];
      else begin
        case (addr)
          5'd0:  r0  <= di;
          5'd1:  r1  <= di;
          5'd2:  r2  <= di;
          5'd3:  r3  <= di;
          5'd4:  r4  <= di[6:0];
          5'd5:  r5  <= di[4:0];
          5'd6:  r6  <= di[6:0];
          5'd7:  r7  <= di[6:0];
          5'd8:  r8  <= di[1:0];
          5'd9:  r9  <= di[4:0];
          5'd10: r10 <= di[6:0];
          5'd11: r11 <= di[4:0];
          5'd12: r12 <= di[5:0];
          5'd13: r13 <= di;
          5'd14: r14 <= di[5:0];
          5'd15: r15 <= di;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcc <= '0; vcc <= '0; rac <= '0; in_adj <= 1'b0; field_q <= 1'b0;
      ma_row <= '0; hs_cnt <= '0; vs_cnt <= '0; blink_cnt <= '0;
      hsync <= 1'b0; vsync <= 1'b0; de <= 1'b0; cursor <= 1'b0;
      hblank <= 1'b1; vblank <= 1'b1; field <= 1'b0; ma <= '0; ra <= '0;
    end else if (clken && enable) begin
      hsync  <= hs_now;
      vsync  <= vs_now;
      hblank <= hb;
      vblank <= vb;
      de     <= !hb && !vb;
      cursor <= cur_now;
      field  <= field_q;
      ma     <= ma_now;
      ra     <= rac;
      // A shortened R0 simply lets hcc run on and overflow back to 0.
      hcc <= line_end ? 8'd0 : hcc + 8'd1;
      if (hs_start)              hs_cnt <= r3[3:0] - 4'd1;
      else if (hs_cnt != 4'd0)   hs_cnt <= hs_cnt - 4'd1;
      if (line_end) begin
        // Width field of 0 wraps to 15 remaining lines, i.e. 16 in total.
        if (vs_start)            vs_cnt <= r3[7:4] - 4'd1;
        else if (vs_cnt != 4'd0) vs_cnt <= vs_cnt - 4'd1;
        if (frame_end) begin
          vcc <= '0; rac <= '0; in_adj <= 1'b0;
          field_q   <= ~field_q;
          blink_cnt <= blink_cnt + 6'd1;
          ma_row    <= {r12, r13};
        end else if (in_adj) begin
          rac <= rac + 5'd1;
        end else if (last_row) begin
          rac    <= '0;
          vcc    <= vcc + 7'd1;
          in_adj <= enter_adj;
          ma_row <= base + {6'd0, r1};
        end else begin
          rac    <= rac + 5'd1;
          ma_row <= base;
        end
      end
    end
  end
endmodule

// File: tb/tb_um6845r_crtc.sv
// Bench for um6845r_crtc: read map, full-frame timing under random clken/enable
// against a time-indexed frame model, and mid-line reset recovery.
module tb_um6845r_crtc;
  logic clock = 0, reset = 0, crtc_type = 0, clken = 0, enable = 0;
  logic n_cs = 1, r_nw = 1, rs = 0;
  logic [7:0] di = 0, dout;
  logic hsync, vsync, de, hblank, vblank, field, cursor;
  logic [13:0] ma;
  logic [4:0] ra;

  int vecs = 0, fails = 0;
  int s = 0, cyc = 0;
  bit cur_en = 1;

  typedef struct packed {
    logic hs, vs, de, hb, vb, fld, cur;
    logic [13:0] ma;
    logic [4:0]  ra;
  } exp_t;

  um6845r_crtc dut (
    .clock(clock), .reset(reset), .crtc_type(crtc_type), .clken(clken),
    .enable(enable), .n_cs(n_cs), .r_nw(r_nw), .rs(rs), .di(di), .dout(dout),
    .hsync(hsync), .vsync(vsync), .de(de), .hblank(hblank), .vblank(vblank),
    .field(field), .cursor(cursor), .ma(ma), .ra(ra)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t reset_vals();
    exp_t e;
    e = '0; e.hb = 1; e.vb = 1;
    return e;
  endfunction

  // Frame model: 64 characters per line, 31 rows of 8 lines + 2 adjust lines.
  function automatic exp_t frame_model(input int idx, input bit cen);
    exp_t e;
    int f, r, l, h;
    f = idx / 16000; r = idx % 16000; l = r / 64; h = r % 64;
    e.hb  = (h >= 40);
    e.vb  = (l >= 200);
    e.de  = !e.hb && !e.vb;
    e.hs  = (h >= 50 && h <= 57);
    e.vs  = (l >= 216 && l <= 218);
    e.fld = f[0];
    e.ma  = 14'(16 + 40 * (l / 8) + h);
    e.ra  = 5'(l % 8);
    e.cur = cen && e.de && (e.ma == 14'h0012) && (e.ra <= 5'd7);
    return e;
  endfunction

  task automatic chk_out(input string ph, input exp_t e);
    chk({ph, ".hsync"},  hsync,  e.hs);
    chk({ph, ".vsync"},  vsync,  e.vs);
    chk({ph, ".de"},     de,     e.de);
    chk({ph, ".hblank"}, hblank, e.hb);
    chk({ph, ".vblank"}, vblank, e.vb);
    chk({ph, ".field"},  field,  e.fld);
    chk({ph, ".cursor"}, cursor, e.cur);
    chk({ph, ".ma"},     ma,     e.ma);
    chk({ph, ".ra"},     ra,     e.ra);
  endtask

  task automatic wr(input logic rsel, input logic [7:0] d);
    @(negedge clock);
    clken = 1; n_cs = 0; r_nw = 0; rs = rsel; di = d;
    @(posedge clock); #1;
    n_cs = 1; r_nw = 1;
  endtask

  task automatic wreg(input logic [4:0] a, input logic [7:0] d);
    wr(1'b0, {3'b000, a});
    wr(1'b1, d);
  endtask

  task automatic rchk(input string tag, input logic [4:0] a, input logic t, input logic [7:0] e);
    wr(1'b0, {3'b000, a});
    @(negedge clock);
    crtc_type = t; n_cs = 0; r_nw = 1; rs = 1;
    #1 chk(tag, dout, e);
    n_cs = 1;
  endtask

  // Randomised clken/enable; s counts character steps that actually advanced.
  task automatic run_to(input int target);
    forever begin
      @(negedge clock);
      if (s == 0) chk_out("run", reset_vals());
      else        chk_out("run", frame_model(s - 1, cur_en));
      if (s >= target || cyc > 60000) break;
      clken  = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 15) != 0);
      @(posedge clock);
      cyc++;
      if (clken && enable) s++;
    end
    chk("run.budget", s, target);
  endtask

  initial begin
    // Reset holds everything regardless of clken/enable.
    clken = 1; enable = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_out("reset", reset_vals());
    enable = 0;
    @(negedge clock);
    reset = 1;

    wreg(0, 8'd63); wreg(1, 8'd40); wreg(2, 8'd50); wreg(3, 8'h38);
    wreg(4, 8'd30); wreg(5, 8'd2);  wreg(6, 8'd25); wreg(7, 8'd27);
    wreg(8, 8'h03); wreg(9, 8'd7);  wreg(10, 8'h00); wreg(11, 8'd7);
    wreg(12, 8'h2A); wreg(13, 8'h10); wreg(14, 8'h00); wreg(15, 8'h12);

    rchk("rd.r12.t0", 12, 0, 8'h00);
    rchk("rd.r12.t1", 12, 1, 8'h2A);
    rchk("rd.r13.t0", 13, 0, 8'h00);
    rchk("rd.r13.t1", 13, 1, 8'h10);
    rchk("rd.r15.t0", 15, 0, 8'h12);
    rchk("rd.r15.t1", 15, 1, 8'h12);
    rchk("rd.r0",      0, 1, 8'h00);
    rchk("rd.r8",      8, 1, 8'h00);
    wreg(12, 8'h00);
    rchk("rd.r12.t1b", 12, 1, 8'h00);
    @(negedge clock);
    n_cs = 0; r_nw = 1; rs = 0;
    crtc_type = 1; #1 chk("rd.status.t1", dout, 8'h20);
    crtc_type = 0; #1 chk("rd.status.t0", dout, 8'h00);
    n_cs = 1; #1 chk("rd.ncs", dout, 8'hFF);
    clken = 0; n_cs = 0; r_nw = 0; rs = 1;
    #1 chk("rd.write", dout, 8'hFF);
    n_cs = 1; r_nw = 1;

    // Full frame, then kill the cursor during vertical adjust and run on.
    run_to(15900);
    enable = 0;
    wreg(10, 8'h20);
    cur_en = 0;
    run_to(16700);

    // Asynchronous reset mid-line.
    @(negedge clock);
    clken = 0; enable = 1;
    reset = 0;
    #1 chk_out("rst_mid", reset_vals());
    @(negedge clock);
    reset = 1; clken = 1; enable = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("post.hsync", hsync, 1'b0);
      chk("post.ma", ma, 14'd0);
    end
    enable = 0;
    wreg(0, 8'd63); wreg(1, 8'd40); wreg(2, 8'd50); wreg(3, 8'h08);
    wreg(6, 8'd25); wreg(7, 8'd27);
    @(negedge clock);
    clken = 1; enable = 1;
    for (int k = 1; k <= 130; k++) begin
      int h;
      @(negedge clock);
      h = (k - 1) % 64;
      chk("re.ma",     ma,     14'(h));
      chk("re.hsync",  hsync,  (h >= 50 && h <= 57));
      chk("re.de",     de,     (h < 40));
      chk("re.hblank", hblank, (h >= 40));
      chk("re.ra",     ra,     5'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/um6845r_crtc.md
UM6845R_CRTC -- requirements
Module: um6845r_crtc

Interface
REQ-001 clock  in  1  system clock; all state changes on its rising edge, gated by clken.
REQ-002 reset  in  1  asynchronous, active-low; clears all registers, counters and outputs.
REQ-003 type  in  1  0 = HD6845S read-map, 1 = UM6845R read-map.
REQ-004 clken  in  1  character-clock enable; counters and register writes advance only when high.
REQ-005 enable  in  1  when low, counters hold and outputs keep their values.
REQ-006 n_cs  in  1  chip select, active-low.
REQ-007 r_nw  in  1  1 = read, 0 = write.
REQ-008 rs  in  1  0 = address register, 1 = data register.
REQ-009 di  in  8  CPU write data.
REQ-010 do  out  8  CPU read data, combinational.
REQ-011 hsync, vsync, de, hblank, vblank, field, cursor  out  1 each  registered video timing outputs.
REQ-012 ma  out  14  memory address; ra  out  5  raster (scanline) address.

Function
REQ-013 Write when clken && !n_cs && !r_nw: rs=0 loads address register <= di[4:0]; rs=1 loads R[addr] <= di (widths: R0-R3 8b, R4 7b, R5 5b, R6-R7 7b, R8 2b, R9 5b, R10 7b, R11 5b, R12/R14 6b, R13/R15 8b); addr > 15 ignored.
REQ-014 Read (!n_cs && r_nw, rs=1): R14/R15 always readable; R12/R13 readable only when type=1; all other addresses return 0x00.
REQ-015 Read with rs=0 returns {2'b00, vblank, 5'b0} when type=1, 0x00 when type=0.
REQ-016 do = 0xFF when n_cs high or r_nw low.
REQ-017 Horizontal counter hcc 0..R0: wraps to 0 on the clken after hcc==R0, which also advances the line logic.
REQ-018 Scanline counter ra 0..R9: wraps to 0 on line end when ra==R9, incrementing row counter vcc (7b).
REQ-019 Frame end: when vcc==R4 && ra==R9 at line end, enter vertical-adjust for R5 extra lines (R5=0 -> none), then vcc=0, ra=0, field toggles.
REQ-020 ma: at frame start ma_row <= {R12,R13}; ma = ma_row + hcc; at line end with ra==R9, ma_row <= ma_row + R1; 14-bit wrap-around.
REQ-021 hblank = (hcc >= R1); vblank = (vcc >= R6) or in vertical-adjust; de = !hblank && !vblank.
REQ-022 hsync asserts at hcc==R2 for R3[3:0] characters; width 0 -> no hsync.
REQ-023 vsync asserts at line start when vcc==R7 && ra==0, lasts R3[7:4] lines; 0 -> 16 lines.
REQ-024 cursor = de && ma=={R14,R15} && R10[4:0] <= ra <= R11 && blink_on.
REQ-025 Blink by R10[6:5]: 00 always on; 01 off; 10 toggle every 16 fields; 11 toggle every 32 fields.
REQ-026 R8 interlace/skew bits are stored and readable-as-0 but have no timing effect.
REQ-027 Register writes take effect on the next clken; a write to R0 below the current hcc causes wrap at 255 back to 0 (no lock-up).
REQ-028 Outputs update one clken after the counter state that produces them (1-cycle registered latency).

Reset
REQ-029 While reset low: R0-R15 = 0, address register = 0, hcc = vcc = ra = 0, ma_row = 0, field = 0, blink counter = 0.
REQ-030 While reset low: hsync = vsync = de = cursor = 0, hblank = vblank = 1, ma = 0, ra = 0.
REQ-031 Reset asserted mid-frame clears state immediately, independent of clken; counting resumes from 0 on the first clken after release.

Verification
REQ-032 Program R0=63,R1=40,R2=50,R3=0x38 -> period 64 clken, hsync high for exactly 8 clken starting at hcc=50, de high hcc 0..39.
REQ-033 R4=30,R5=2,R6=25,R7=27,R9=7 -> frame = 31*8+2 = 250 lines, vblank from line 200, vsync 3 lines starting at line 216.
REQ-034 R12=0x00,R13=0x10,R1=40 -> ma=0x0010 at first de character, 0x0038 at start of row 1, constant through ra 0..7 within a row.
REQ-035 R14=0x00,R15=0x12,R10=0x00,R11=7 -> cursor high only at ma=0x0012 for all scanlines; R10=0x20 -> cursor never high.
REQ-036 type=0 read R12 -> 0x00; type=1 -> written value; read R14 -> written value both types; n_cs high -> 0xFF.
REQ-037 Assert reset mid-line -> all outputs at reset values same cycle; after release, hcc restarts at 0, hsync absent until hcc==R2 reprogrammed.
